kong_sprite_anim: RTL and testbench
===================================

Name: kong_sprite_anim

Overview:
- Parametrised successor to the Kong debug renderer. Runs Kong's throw animation as a frame-timed state machine (NORMAL -> GET -> HOLD -> DROP -> NORMAL).
- Emits a one-cycle barrel_spawn pulse at the drop instant and draws the Kong bounding box in the per-state colour.
- Sits between game logic (throw requests, frame ticks) and the VGA pixel mux. The pixel path is registered, with overflow-safe box arithmetic.

Parameters:
- WIDTH, 120, sprite box width in pixels (even, >= 2).
- HEIGHT, 160, sprite box height in pixels (even, >= 2).
- GET_FRAMES, 16, frames spent in GET (>= 1).
- HOLD_FRAMES, 24, frames spent in HOLD (>= 1).
- DROP_FRAMES, 8, frames spent in DROP (>= 1).
- CNT_W, 8, frame counter width; must hold max(*_FRAMES).

Ports:
- clk  in  1  system/pixel clock.
- rst_n  in  1  synchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per VGA frame (end of visible area).
- state  in  1  game state: 0 = KONG_INITIAL, 1 = KONG_PLAYING.
- throw_req  in  1  one-cycle request to throw a barrel.
- cx  in  10  current scan column.
- cy  in  9  current scan row.
- posX  in  10  Kong centre column.
- posY  in  9  Kong centre row.
- ocolor  out  12  RGB444 pixel colour.
- opaque  out  1  1 when ocolor is Kong (pixel inside box while playing).
- animation_state  out  2  current animation state.
- barrel_spawn  out  1  one-cycle pulse on entry to DROP.
- busy  out  1  1 whenever animation_state != NORMAL.

Behaviour:
- Reset (rst_n = 0 at a clk edge) forces these values:
  - animation_state = NORMAL, counter = 0, pending = 0
  - barrel_spawn = 0, busy = 0
  - ocolor = 12'hFFF, opaque = 0
- Reset mid-animation aborts immediately. No spawn pulse is produced.
- Encodings: NORMAL = 2'b00, GET = 2'b01, HOLD = 2'b10, DROP = 2'b11.
- FSM, evaluated every clk:
  - state == KONG_INITIAL: force NORMAL, counter = 0, pending = 0. throw_req is ignored.
  - NORMAL: if throw_req or pending, go to GET, counter = 0, pending = 0.
  - GET, HOLD, DROP: counter increments only on frame_tick. When a tick arrives with counter == *_FRAMES-1, advance to the next state (GET -> HOLD -> DROP -> NORMAL) and clear counter. Each state therefore lasts exactly *_FRAMES ticks.
  - barrel_spawn: registered, high for exactly the one cycle after the HOLD -> DROP transition edge.
- throw_req while busy sets pending. Only one request is queued; further requests are dropped.
  - pending is consumed on the cycle NORMAL is re-entered, so GET is entered on the following cycle.
- throw_req coincident with the DROP -> NORMAL transition sets pending.
- busy is combinational from the animation_state register.
- Pixel path, 1-cycle latency (inputs at edge N, outputs valid after edge N+1):
  - Arithmetic is 11-bit unsigned with no wrap.
  - Horizontal: inside_x = (cx + WIDTH/2 >= posX) && (cx + WIDTH/2 < posX + WIDTH). This covers columns posX-WIDTH/2 .. posX+WIDTH/2-1.
  - Vertical: same rule with cy, posY, HEIGHT.
  - If state == PLAYING && inside_x && inside_y: opaque = 1 and ocolor is set by the animation_state value sampled in the same cycle. Colours: NORMAL 0FF, GET 00F, HOLD 0F0, DROP F00.
  - Otherwise opaque = 0 and ocolor = FFF.
  - A box partially off-screen (posX < WIDTH/2) clips cleanly. There is no aliasing at cx near 1023.

Decomposition:
- Package kong_pkg holds:
  - KONG_INITIAL/KONG_PLAYING and the four animation encodings
  - the colour constants KONG_COL_NORMAL/GET/HOLD/DROP/BG
- Sub-module kong_anim_fsm contains FSM, counter, pending and barrel_spawn. The top module adds the registered box test and colour mux.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles while driving throw_req = 1 -> animation_state = 0, busy = 0, barrel_spawn = 0, ocolor = FFF, opaque = 0.
- Box edges: PLAYING, NORMAL, posX = 300, posY = 200. cx = 240 and cx = 359 at cy = 200 -> ocolor 0FF, opaque 1. cx = 239 and cx = 360 -> FFF, 0. cy = 120 -> inside; cy = 280 -> outside. Results appear one cycle later.
- Throw sequence, with GET_FRAMES = 2, HOLD_FRAMES = 3, DROP_FRAMES = 1:
  - throw_req -> GET for 2 ticks, then HOLD for 3 ticks.
  - barrel_spawn is high exactly 1 cycle, after the HOLD -> DROP edge.
  - DROP for 1 tick, then NORMAL. Total of 1 spawn.
- Queueing: 3 throw_req pulses during HOLD -> after return to NORMAL, exactly one further GET..DROP cycle and exactly 2 spawns total.
- Abort: state -> INITIAL during HOLD -> next cycle NORMAL, no spawn, ocolor = FFF for every pixel. A later throw_req while INITIAL is ignored.
- Clipping: posX = 10, posY = 5, PLAYING. cx = 0, cy = 0 -> inside (opaque 1). cx = 1023, cy = 0 -> outside. cx = 70 -> outside, cx = 69 -> inside.

Source files
------------

// File: rtl/kong_pkg.sv
// kong_pkg: game-state and animation encodings plus sprite colours for the Kong animator
package kong_pkg;
    typedef enum logic {
        KONG_INITIAL = 1'b0,
        KONG_PLAYING = 1'b1
    } game_state_e;
    typedef enum logic [1:0] {
        ANIM_NORMAL = 2'b00,
        ANIM_GET    = 2'b01,
        ANIM_HOLD   = 2'b10,
        ANIM_DROP   = 2'b11
    } anim_state_e;
    localparam logic [11:0] KONG_COL_NORMAL = 12'h0FF;
    localparam logic [11:0] KONG_COL_GET    = 12'h00F;
    localparam logic [11:0] KONG_COL_HOLD   = 12'h0F0;
    localparam logic [11:0] KONG_COL_DROP   = 12'hF00;
    localparam logic [11:0] KONG_COL_BG     = 12'hFFF;
    function automatic logic [11:0] anim_colour(anim_state_e s);
        return s == ANIM_GET  ? KONG_COL_GET  :
               s == ANIM_HOLD ? KONG_COL_HOLD :
               s == ANIM_DROP ? KONG_COL_DROP : KONG_COL_NORMAL;
    endfunction
endpackage

// File: rtl/kong_sprite_anim_if.sv
// kong_sprite_anim_if: game-logic / scan inputs and pixel / animation outputs of the Kong animator
interface kong_sprite_anim_if;
    import kong_pkg::*;
    logic        frame_tick;
    logic        state;
    logic        throw_req;
    logic [9:0]  cx;
    logic [8:0]  cy;
    logic [9:0]  posX;
    logic [8:0]  posY;
    logic [11:0] ocolor;
    logic        opaque;
    anim_state_e animation_state;
    logic        barrel_spawn;
    logic        busy;
    modport master (
        output frame_tick, state, throw_req, cx, cy, posX, posY,
        input  ocolor, opaque, animation_state, barrel_spawn, busy
    );
    modport slave (
        input  frame_tick, state, throw_req, cx, cy, posX, posY,
        output ocolor, opaque, animation_state, barrel_spawn, busy
    );
endinterface

// File: rtl/kong_anim_fsm.sv
// kong_anim_fsm: frame-timed NORMAL->GET->HOLD->DROP throw sequencer with one queued request
module kong_anim_fsm
    import kong_pkg::*;
#(
    parameter int GET_FRAMES  = 16,
    parameter int HOLD_FRAMES = 24,
    parameter int DROP_FRAMES = 8,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        playing,
    input  logic        frame_tick,
    input  logic        throw_req,
    output anim_state_e anim,
    output logic        barrel_spawn,
    output logic        busy
);
    localparam logic [CNT_W-1:0] GET_LAST  = CNT_W'(GET_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(DROP_FRAMES - 1);

    anim_state_e      anim_q, anim_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             spawn_q, spawn_d;
    logic             last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anim_q    <= ANIM_NORMAL;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            spawn_q   <= 1'b0;
        end else begin
            anim_q    <= anim_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            spawn_q   <= spawn_d;
        end
    end

    always_comb begin
        anim_d    = anim_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        last      = cnt_q == (anim_q == ANIM_GET  ? GET_LAST :
                              anim_q == ANIM_HOLD ? HOLD_LAST : DROP_LAST);
        if (!playing) begin
            anim_d    = ANIM_NORMAL;
            cnt_d     = '0;
            pending_d = 1'b0;
        end else if (anim_q == ANIM_NORMAL) begin
            if (throw_req || pending_q) begin
                anim_d    = ANIM_GET;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
        end else begin
            // a request while busy is remembered once; DROP wraps to NORMAL via the 2-bit add
            pending_d = pending_q | throw_req;
            if (frame_tick) begin
                cnt_d  = last ? '0 : cnt_q + 1'b1;
                anim_d = last ? anim_state_e'(anim_q + 2'd1) : anim_q;
            end
        end
    end

    always_comb begin
        spawn_d = anim_q == ANIM_HOLD && anim_d == ANIM_DROP;
        busy    = anim_q != ANIM_NORMAL;
    end

    assign anim         = anim_q;
    assign barrel_spawn = spawn_q;
endmodule

// File: rtl/kong_sprite_anim.sv
// kong_sprite_anim: Kong throw animation plus registered bounding-box pixel colouring
module kong_sprite_anim
    import kong_pkg::*;
#(
    parameter int WIDTH       = 120,
    parameter int HEIGHT      = 160,
    parameter int GET_FRAMES  = 16,
    parameter int HOLD_FRAMES = 24,
    parameter int DROP_FRAMES = 8,
    parameter int CNT_W       = 8
) (
    input logic clk,
    input logic rst_n,
    kong_sprite_anim_if.slave bus
);
    localparam logic [10:0] HALF_W = 11'(WIDTH / 2);
    localparam logic [10:0] FULL_W = 11'(WIDTH);
    localparam logic [10:0] HALF_H = 11'(HEIGHT / 2);
    localparam logic [10:0] FULL_H = 11'(HEIGHT);

    anim_state_e anim;
    logic        playing, inside_x, inside_y;
    logic [10:0] sx, sy;
    logic        opaque_q, opaque_d;
    logic [11:0] ocolor_q, ocolor_d;

    assign playing = bus.state == KONG_PLAYING;

    kong_anim_fsm #(
        .GET_FRAMES (GET_FRAMES),
        .HOLD_FRAMES(HOLD_FRAMES),
        .DROP_FRAMES(DROP_FRAMES),
        .CNT_W      (CNT_W)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .playing     (playing),
        .frame_tick  (bus.frame_tick),
        .throw_req   (bus.throw_req),
        .anim        (anim),
        .barrel_spawn(bus.barrel_spawn),
        .busy        (bus.busy)
    );

    // shifting the scan point by half the box keeps every term non-negative, so no wrap near 0 or 1023
    always_comb begin
        sx       = {1'b0, bus.cx} + HALF_W;
        sy       = {2'b0, bus.cy} + HALF_H;
        inside_x = sx >= {1'b0, bus.posX} && sx < {1'b0, bus.posX} + FULL_W;
        inside_y = sy >= {2'b0, bus.posY} && sy < {2'b0, bus.posY} + FULL_H;
        opaque_d = playing && inside_x && inside_y;
        ocolor_d = opaque_d ? anim_colour(anim) : KONG_COL_BG;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opaque_q <= 1'b0;
            ocolor_q <= KONG_COL_BG;
        end else begin
            opaque_q <= opaque_d;
            ocolor_q <= ocolor_d;
        end
    end

    assign bus.opaque          = opaque_q;
    assign bus.ocolor          = ocolor_q;
    assign bus.animation_state = anim;
endmodule

// File: tb/tb_kong_sprite_anim.sv
// tb_kong_sprite_anim: vector table for the box test, hand sequences for throw, queueing and abort
module tb_kong_sprite_anim;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kong_sprite_anim_if bus();

    kong_sprite_anim #(
        .WIDTH(120), .HEIGHT(160), .GET_FRAMES(2), .HOLD_FRAMES(3), .DROP_FRAMES(1), .CNT_W(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [9:0]  cx;
        logic [8:0]  cy;
        logic [9:0]  px;
        logic [8:0]  py;
        logic        st;
        logic [11:0] col;
        logic        op;
    } vec_t;
    typedef struct {
        logic [11:0] col;
        logic        op;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int spawns = 0;
    int base;

    always @(negedge clk) if (bus.barrel_spawn === 1'b1) spawns++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic throw_pulse();
        bus.throw_req = 1'b1;
        step();
        bus.throw_req = 1'b0;
    endtask

    task automatic px(input vec_t v, input string name);
        exp_t e;
        bus.cx = v.cx; bus.cy = v.cy; bus.posX = v.px; bus.posY = v.py; bus.state = v.st;
        sb.push_back('{col: v.col, op: v.op});
        step();
        e = sb.pop_front();
        chk({name, " ocolor"}, 32'(bus.ocolor), 32'(e.col));
        chk({name, " opaque"}, 32'(bus.opaque), 32'(e.op));
    endtask

    vec_t vt[16];

    initial begin
        vt[0]  = '{240, 200, 300, 200, 1, 12'h0FF, 1};
        vt[1]  = '{359, 200, 300, 200, 1, 12'h0FF, 1};
        vt[2]  = '{239, 200, 300, 200, 1, 12'hFFF, 0};
        vt[3]  = '{360, 200, 300, 200, 1, 12'hFFF, 0};
        vt[4]  = '{300, 120, 300, 200, 1, 12'h0FF, 1};
        vt[5]  = '{300, 119, 300, 200, 1, 12'hFFF, 0};
        vt[6]  = '{300, 279, 300, 200, 1, 12'h0FF, 1};
        vt[7]  = '{300, 280, 300, 200, 1, 12'hFFF, 0};
        vt[8]  = '{0,   0,   10,  5,   1, 12'h0FF, 1};
        vt[9]  = '{1023, 0,  10,  5,   1, 12'hFFF, 0};
        vt[10] = '{70,  0,   10,  5,   1, 12'hFFF, 0};
        vt[11] = '{69,  0,   10,  5,   1, 12'h0FF, 1};
        vt[12] = '{0,   84,  10,  5,   1, 12'h0FF, 1};
        vt[13] = '{0,   85,  10,  5,   1, 12'hFFF, 0};
        vt[14] = '{300, 200, 300, 200, 0, 12'hFFF, 0};
        vt[15] = '{511, 511, 511, 511, 1, 12'h0FF, 1};

        bus.frame_tick = 0; bus.state = 1; bus.throw_req = 1;
        bus.cx = 300; bus.cy = 200; bus.posX = 300; bus.posY = 200;
        rst_n = 0;
        repeat (3) step();
        chk("reset anim", 32'(bus.animation_state), 0);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset spawn", 32'(bus.barrel_spawn), 0);
        chk("reset ocolor", 32'(bus.ocolor), 32'hFFF);
        chk("reset opaque", 32'(bus.opaque), 0);
        bus.throw_req = 0;
        rst_n = 1;
        step();
        chk("idle after reset", 32'(bus.animation_state), 0);

        for (int i = 0; i < 16; i++) px(vt[i], $sformatf("box[%0d]", i));

        // throw sequence
        throw_pulse();
        chk("throw get", 32'(bus.animation_state), 1);
        chk("throw busy", 32'(bus.busy), 1);
        px('{300, 200, 300, 200, 1, 12'h00F, 1}, "get colour");
        tick();
        chk("get after 1 tick", 32'(bus.animation_state), 1);
        tick();
        chk("hold entered", 32'(bus.animation_state), 2);
        px('{300, 200, 300, 200, 1, 12'h0F0, 1}, "hold colour");
        tick(); tick();
        chk("hold after 2 ticks", 32'(bus.animation_state), 2);
        chk("no spawn in hold", 32'(spawns), 0);
        tick();
        chk("drop entered", 32'(bus.animation_state), 3);
        chk("spawn high", 32'(bus.barrel_spawn), 1);
        px('{300, 200, 300, 200, 1, 12'hF00, 1}, "drop colour");
        chk("spawn low", 32'(bus.barrel_spawn), 0);
        tick();
        chk("back to normal", 32'(bus.animation_state), 0);
        chk("normal busy", 32'(bus.busy), 0);
        chk("one spawn", 32'(spawns), 1);

        // queueing
        base = spawns;
        throw_pulse();
        tick(); tick();
        chk("queue hold", 32'(bus.animation_state), 2);
        repeat (3) begin
            throw_pulse();
            step();
        end
        chk("queue still hold", 32'(bus.animation_state), 2);
        repeat (3) tick();
        tick();
        chk("queue normal", 32'(bus.animation_state), 0);
        step();
        chk("queued get", 32'(bus.animation_state), 1);
        repeat (6) tick();
        chk("queued normal", 32'(bus.animation_state), 0);
        repeat (4) step();
        chk("no third run", 32'(bus.animation_state), 0);
        chk("two spawns", 32'(spawns - base), 2);

        // request coincident with DROP -> NORMAL
        throw_pulse();
        repeat (5) tick();
        chk("edge drop", 32'(bus.animation_state), 3);
        bus.throw_req = 1; bus.frame_tick = 1;
        step();
        bus.throw_req = 0; bus.frame_tick = 0;
        chk("edge normal", 32'(bus.animation_state), 0);
        step();
        chk("edge requeued get", 32'(bus.animation_state), 1);
        repeat (6) tick();
        chk("edge done", 32'(bus.animation_state), 0);

        // abort
        base = spawns;
        throw_pulse();
        tick(); tick();
        chk("abort hold", 32'(bus.animation_state), 2);
        bus.state = 0;
        step();
        chk("abort normal", 32'(bus.animation_state), 0);
        chk("abort busy", 32'(bus.busy), 0);
        px('{300, 200, 300, 200, 0, 12'hFFF, 0}, "abort centre");
        px('{240, 120, 300, 200, 0, 12'hFFF, 0}, "abort corner");
        throw_pulse();
        step();
        chk("initial ignores throw", 32'(bus.animation_state), 0);
        bus.state = 1;
        step(); step();
        chk("no pending after initial", 32'(bus.animation_state), 0);
        chk("abort no spawn", 32'(spawns - base), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
